// File: rtl/ladder_ctrl.sv
// ladder_ctrl: sequencer for a Montgomery-ladder style scalar walk.
// For each KEY bit from N-2 down to 0 it issues one doubling and one
// addition to external arithmetic stages, collects both results (any
// order, any latency) and swaps them back into the ladder registers.
//
// Ports
//   CLK, RST_N                  clock, synchronous active-low reset
//   START, KEY, *_INIT          operation request, scalar, start coordinates
//   DBL_*                       handshake/operands/results of doubling stage
//   ADD_*                       handshake/operands/results of addition stage
//   BUSY, DONE, ERROR           status (DONE is a one-cycle pulse)
//   OUT_X1/Z1/X2/Z2             current ladder registers
//
// Build option
//   LADDER_TIMEOUT_EN  adds a WAIT-state watchdog limited by TMO; on expiry the
//                      operation ends with ERROR=1 and a DONE pulse.
//
// state  | meaning
// IDLE   | waiting for START
// ISSUE  | one-cycle request to both stages
// WAIT   | collecting the two results
// UPDATE | write results back, step bit index
// FINISH | one-cycle DONE pulse
module ladder_ctrl #(
    parameter int N   = 233,
    parameter int TMO = 1023
) (
    input  logic         CLK,
    input  logic         RST_N,
    input  logic         START,
    input  logic [N-1:0] KEY,
    input  logic [N-1:0] X1_INIT,
    input  logic [N-1:0] Z1_INIT,
    input  logic [N-1:0] X2_INIT,
    input  logic [N-1:0] Z2_INIT,
    output logic         DBL_IN_VALID,
    output logic [N-1:0] DBL_X,
    output logic [N-1:0] DBL_Z,
    input  logic         DBL_OUT_VALID,
    input  logic [N-1:0] DBL_X_RES,
    input  logic [N-1:0] DBL_Z_RES,
    output logic         ADD_IN_VALID,
    output logic [N-1:0] ADD_X1,
    output logic [N-1:0] ADD_Z1,
    output logic [N-1:0] ADD_X2,
    output logic [N-1:0] ADD_Z2,
    input  logic         ADD_OUT_VALID,
    input  logic [N-1:0] ADD_X_RES,
    input  logic [N-1:0] ADD_Z_RES,
    output logic         BUSY,
    output logic         DONE,
    output logic         ERROR,
    output logic [N-1:0] OUT_X1,
    output logic [N-1:0] OUT_Z1,
    output logic [N-1:0] OUT_X2,
    output logic [N-1:0] OUT_Z2
);

    localparam int IW = (N > 2) ? $clog2(N) : 1;

    if (TMO < 1) begin : g_tmo_range
        $error("ladder_ctrl: TMO must be at least 1");
    end

    typedef enum logic [2:0] {
        S_IDLE, S_ISSUE, S_WAIT, S_UPDATE, S_FINISH
    } state_t;

    state_t         r_state, w_state_nxt;
    logic [IW-1:0]  r_i;
    logic [N-1:0]   r_x1, r_z1, r_x2, r_z2;
    logic [N-1:0]   r_dbl_x, r_dbl_z, r_add_x, r_add_z;
    logic           r_dbl_done, r_add_done;
    logic           w_key_bit;
    logic           w_both_done;
    logic           w_tmo_hit;

    assign w_key_bit   = KEY[r_i];
    assign w_both_done = r_dbl_done & r_add_done;

`ifdef LADDER_TIMEOUT_EN
    localparam int CW = $clog2(TMO + 1);
    logic [CW-1:0] r_tmo_cnt;
    logic          r_error;

    // Counter would reach TMO on this WAIT edge; a completed pair wins.
    assign w_tmo_hit = (r_state == S_WAIT) && !w_both_done
                       && (r_tmo_cnt == CW'(TMO - 1));

    always_ff @(posedge CLK) begin
        if (!RST_N) begin
            r_tmo_cnt <= '0;
            r_error   <= 1'b0;
        end else begin
            if (r_state == S_ISSUE)
                r_tmo_cnt <= '0;
            else if (r_state == S_WAIT)
                r_tmo_cnt <= r_tmo_cnt + CW'(1);
            if (r_state == S_IDLE && START)
                r_error <= 1'b0;
            else if (w_tmo_hit)
                r_error <= 1'b1;
        end
    end

    assign ERROR = r_error;
`else
    assign w_tmo_hit = 1'b0;
    assign ERROR     = 1'b0;
`endif

    always_ff @(posedge CLK) begin
        if (!RST_N)
            r_state <= S_IDLE;
        else
            r_state <= w_state_nxt;
    end

    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            S_IDLE:   if (START) w_state_nxt = S_ISSUE;
            S_ISSUE:  w_state_nxt = S_WAIT;
            S_WAIT: begin
                if (w_both_done)
                    w_state_nxt = S_UPDATE;
                else if (w_tmo_hit)
                    w_state_nxt = S_FINISH;
            end
            S_UPDATE: w_state_nxt = (r_i == '0) ? S_FINISH : S_ISSUE;
            S_FINISH: w_state_nxt = S_IDLE;
            default:  w_state_nxt = S_IDLE;
        endcase
    end

    always_ff @(posedge CLK) begin
        if (!RST_N) begin
            r_i        <= '0;
            r_x1       <= '0;
            r_z1       <= '0;
            r_x2       <= '0;
            r_z2       <= '0;
            r_dbl_x    <= '0;
            r_dbl_z    <= '0;
            r_add_x    <= '0;
            r_add_z    <= '0;
            r_dbl_done <= 1'b0;
            r_add_done <= 1'b0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (START) begin
                        r_x1       <= X1_INIT;
                        r_z1       <= Z1_INIT;
                        r_x2       <= X2_INIT;
                        r_z2       <= Z2_INIT;
                        r_i        <= IW'(N - 2);
                        // a timed-out run may have left one flag set
                        r_dbl_done <= 1'b0;
                        r_add_done <= 1'b0;
                    end
                end
                S_ISSUE, S_WAIT: begin
                    if (DBL_OUT_VALID && !r_dbl_done) begin
                        r_dbl_x    <= DBL_X_RES;
                        r_dbl_z    <= DBL_Z_RES;
                        r_dbl_done <= 1'b1;
                    end
                    if (ADD_OUT_VALID && !r_add_done) begin
                        r_add_x    <= ADD_X_RES;
                        r_add_z    <= ADD_Z_RES;
                        r_add_done <= 1'b1;
                    end
                end
                S_UPDATE: begin
                    if (w_key_bit) begin
                        r_x1 <= r_add_x;
                        r_z1 <= r_add_z;
                        r_x2 <= r_dbl_x;
                        r_z2 <= r_dbl_z;
                    end else begin
                        r_x2 <= r_add_x;
                        r_z2 <= r_add_z;
                        r_x1 <= r_dbl_x;
                        r_z1 <= r_dbl_z;
                    end
                    r_dbl_done <= 1'b0;
                    r_add_done <= 1'b0;
                    if (r_i != '0)
                        r_i <= r_i - IW'(1);
                end
                default: ;
            endcase
        end
    end

    // Operands are pure functions of registers that only move in IDLE/UPDATE,
    // so they stay stable for the whole ISSUE..WAIT window.
    always_comb begin
        BUSY         = (r_state != S_IDLE);
        DONE         = (r_state == S_FINISH);
        DBL_IN_VALID = (r_state == S_ISSUE);
        ADD_IN_VALID = (r_state == S_ISSUE);
        DBL_X        = w_key_bit ? r_x2 : r_x1;
        DBL_Z        = w_key_bit ? r_z2 : r_z1;
        ADD_X1       = r_x1;
        ADD_Z1       = r_z1;
        ADD_X2       = r_x2;
        ADD_Z2       = r_z2;
        OUT_X1       = r_x1;
        OUT_Z1       = r_z1;
        OUT_X2       = r_x2;
        OUT_Z2       = r_z2;
    end

endmodule

// File: doc/ladder_ctrl.md
LADDER_CTRL -- requirements
Module: ladder_ctrl

Interface
REQ-001 SHALL have parameter N, default 233, field width in bits of every coordinate and of KEY.
REQ-002 SHALL have parameter TMO, default 1023, cycle limit for the timeout watchdog.
REQ-003 SHALL have ports: CLK in 1 clock; RST_N in 1 reset, synchronous, active-low.
REQ-004 SHALL have ports: START in 1 start pulse; KEY in N scalar, MSB assumed 1.
REQ-005 SHALL have ports: X1_INIT, Z1_INIT, X2_INIT, Z2_INIT in N each, initial ladder coordinates.
REQ-006 SHALL have ports: DBL_IN_VALID out 1; DBL_X, DBL_Z out N; DBL_OUT_VALID in 1; DBL_X_RES, DBL_Z_RES in N (to/from doubling stage).
REQ-007 SHALL have ports: ADD_IN_VALID out 1; ADD_X1, ADD_Z1, ADD_X2, ADD_Z2 out N; ADD_OUT_VALID in 1; ADD_X_RES, ADD_Z_RES in N (to/from addition stage).
REQ-008 SHALL have ports: BUSY out 1; DONE out 1; ERROR out 1; OUT_X1, OUT_Z1, OUT_X2, OUT_Z2 out N, final coordinates.

Function
REQ-009 SHALL implement states IDLE, ISSUE, WAIT, UPDATE, FINISH.
REQ-010 IDLE with START=1 SHALL latch the four *_INIT values into R_X1/R_Z1/R_X2/R_Z2, set bit index I=N-2, clear ERROR, and go to ISSUE on the same edge.
REQ-011 START outside IDLE SHALL be ignored.
REQ-012 ISSUE SHALL assert DBL_IN_VALID and ADD_IN_VALID for exactly one cycle, then go to WAIT.
REQ-013 Doubling operand SHALL be (R_X2,R_Z2) when KEY[I]=1, else (R_X1,R_Z1).
REQ-014 Addition operands SHALL always be ADD_X1/Z1=R_X1/R_Z1 and ADD_X2/Z2=R_X2/R_Z2.
REQ-015 All operand outputs SHALL stay stable from ISSUE until UPDATE.
REQ-016 Each result SHALL be captured into a holding register, with its done-flag set, on the first cycle its *_OUT_VALID is high in ISSUE or WAIT; later valids in the same iteration SHALL be ignored.
REQ-017 Results SHALL be accepted in either order, and in the same cycle.
REQ-018 WAIT SHALL go to UPDATE on the cycle after both done-flags are set.
REQ-019 *_OUT_VALID in IDLE, UPDATE or FINISH SHALL be ignored.
REQ-020 UPDATE with KEY[I]=1 SHALL write R_X1/R_Z1 from the addition result and R_X2/R_Z2 from the doubling result.
REQ-021 UPDATE with KEY[I]=0 SHALL write R_X2/R_Z2 from the addition result and R_X1/R_Z1 from the doubling result.
REQ-022 UPDATE SHALL clear both done-flags; if I=0, go to FINISH, else decrement I and go to ISSUE.
REQ-023 An operation SHALL consist of exactly N-1 iterations (bits N-2 down to 0); KEY[N-1] SHALL be unused.
REQ-024 FINISH SHALL assert DONE for exactly one cycle and go to IDLE.
REQ-025 OUT_* SHALL continuously reflect R_*; values SHALL hold until the next START.
REQ-026 BUSY SHALL be 1 in every state except IDLE.
REQ-027 Minimum iteration length SHALL be 3 cycles (ISSUE, WAIT, UPDATE) with zero-latency units.

Reset
REQ-028 RST_N=0 at a CLK edge SHALL force IDLE, set all R_* and holding registers to 0, clear the flags, set I=0, and drive BUSY, DONE, ERROR, DBL_IN_VALID and ADD_IN_VALID to 0.
REQ-029 Reset mid-operation SHALL abandon the operation without asserting DONE; *_OUT_VALID arriving after reset SHALL be ignored.

Configuration
REQ-030 With macro LADDER_TIMEOUT_EN defined, a counter SHALL be cleared in ISSUE and increment each WAIT cycle.
REQ-031 With LADDER_TIMEOUT_EN defined, reaching TMO in WAIT SHALL set ERROR=1, pulse DONE for one cycle, and return to IDLE with R_* unchanged.
REQ-032 With LADDER_TIMEOUT_EN defined, ERROR SHALL hold until the next accepted START or reset.
REQ-033 Without LADDER_TIMEOUT_EN, WAIT SHALL wait indefinitely, ERROR SHALL be constant 0, and no counter logic SHALL exist.

Verification
REQ-034 N=8; KEY=8'h80; stub units return DBL=(OpX+1,OpZ+1), ADD=(X1^X2,Z1^Z2), latency 2; INITs 1,2,3,4 -> 7 iterations always take the bit-0 path; DONE after 7×5+1 cycles; OUT matches bench model.
REQ-035 Same stubs, KEY=8'hFF -> every UPDATE takes the bit-1 path; results match model; DONE high exactly one cycle.
REQ-036 ADD latency 0, DBL latency 6; then swapped; then both 3 in the same cycle -> identical outputs in all three cases; no double-capture.
REQ-037 START pulsed again at iteration 3 -> ignored; single DONE. RST_N low during WAIT -> BUSY=0 and OUT_*=0 next cycle, no DONE; a following START runs cleanly.
REQ-038 LADDER_TIMEOUT_EN, TMO=16, DBL never responds -> ERROR=1 and DONE pulse 17 cycles after ISSUE; without the macro -> BUSY stays 1 and ERROR=0.
